if_fetch_queue: RTL and testbench

Instruction-fetch stage directly downstream of the program counter. It issues the current PC to instruction memory over a valid/ready request channel and tracks outstanding requests. In-order responses are pushed into a small fetch queue that feeds decode as {pc, instr} pairs. It generates the PC advance enable (pc_write) and sequential next PC (pc_next), and discards wrong-path fetches on a branch/jump flush.

---
 rtl/if_fetch_queue.sv | 91 +++++++++
 tb/tb_if_fetch_queue.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_queue.sv
// if_fetch_queue: PC-to-imem fetch stage with credit-limited requests, in-flight PC tracking and a decode-facing queue.
// Define FETCH_BYPASS_EN to forward a response straight to decode when the queue is empty (0-cycle latency).
module if_fetch_queue #(
    parameter int FIFO_DEPTH      = 2,
    parameter int MAX_OUTSTANDING = 2,
    parameter int XLEN            = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] pc_current,
    input  logic            pc_flush,
    output logic            pc_write,
    output logic [XLEN-1:0] pc_next,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_instr
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW:0]   DEPTH_L = (CW + 1)'(FIFO_DEPTH);
    localparam logic [OW-1:0] MAXO_L  = OW'(MAX_OUTSTANDING);

    logic [XLEN-1:0] q_pc    [FIFO_DEPTH];
    logic [XLEN-1:0] q_instr [FIFO_DEPTH];
    logic [XLEN-1:0] fl_pc   [FIFO_DEPTH];
    logic [PW-1:0]   q_wr, q_rd, fl_wr, fl_rd;
    logic [CW-1:0]   count;
    logic [OW-1:0]   outstanding, drop;
    logic [CW:0]     credit_sum;
    logic            q_empty, req_hs, rsp_ok, rsp_keep, byp, q_push, q_pop;

    assign q_empty    = count == '0;
    assign credit_sum = (CW + 1)'(outstanding) + (CW + 1)'(count);
    // Outstanding requests reserve queue slots so a response can never find the queue full.
    assign imem_req_valid = rst_n && !pc_flush && (outstanding < MAXO_L) && (credit_sum < DEPTH_L);
    assign req_hs         = imem_req_valid && imem_req_ready;
    assign pc_write       = req_hs;
    assign imem_req_addr  = rst_n ? pc_current : '0;
    assign pc_next        = {pc_current[XLEN-1:2], 2'b00} + XLEN'(4);

    assign rsp_ok   = rst_n && imem_rsp_valid && (outstanding != '0);
    assign rsp_keep = rsp_ok && (drop == '0) && !pc_flush;
`ifdef FETCH_BYPASS_EN
    assign byp = rsp_keep && q_empty;
`else
    assign byp = 1'b0;
`endif
    assign id_valid = !q_empty || byp;
    assign id_pc    = !q_empty ? q_pc[q_rd]    : byp ? fl_pc[fl_rd]  : '0;
    assign id_instr = !q_empty ? q_instr[q_rd] : byp ? imem_rsp_data : '0;
    assign q_pop    = !q_empty && id_ready && !pc_flush;
    assign q_push   = rsp_keep && !(byp && id_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding <= '0;
            drop        <= '0;
            fl_wr       <= '0;
            fl_rd       <= '0;
            q_wr        <= '0;
            q_rd        <= '0;
            count       <= '0;
        end else begin
            outstanding <= outstanding + OW'(req_hs) - OW'(rsp_ok);
            fl_wr       <= fl_wr + PW'(req_hs);
            fl_rd       <= fl_rd + PW'(rsp_ok);
            // A flush marks every request still in flight after this cycle's response as wrong-path.
            drop        <= pc_flush ? outstanding - OW'(rsp_ok) : drop - OW'(rsp_ok && (drop != '0));
            q_wr        <= pc_flush ? '0 : q_wr + PW'(q_push);
            q_rd        <= pc_flush ? '0 : q_rd + PW'(q_pop);
            count       <= pc_flush ? '0 : count + CW'(q_push) - CW'(q_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (req_hs) fl_pc[fl_wr] <= pc_current;
        if (q_push) begin
            q_pc[q_wr]    <= fl_pc[fl_rd];
            q_instr[q_wr] <= imem_rsp_data;
        end
    end

    a_rsp_protocol: assert property (@(posedge clk) disable iff (!rst_n) imem_rsp_valid |-> outstanding != '0);
endmodule

// File: tb/tb_if_fetch_queue.sv
// tb_if_fetch_queue: directed vector table plus stream and bypass sequences for if_fetch_queue.
module tb_if_fetch_queue;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc_current = '0;
    logic        pc_flush = 1'b0;
    logic        imem_req_ready = 1'b1;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        id_ready = 1'b1;
    logic        pc_write, imem_req_valid, id_valid;
    logic [31:0] pc_next, imem_req_addr, id_pc, id_instr;
    int pass_cnt = 0;
    int total = 0;

    if_fetch_queue dut (
        .clk(clk), .rst_n(rst_n), .pc_current(pc_current), .pc_flush(pc_flush),
        .pc_write(pc_write), .pc_next(pc_next), .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_instr(id_instr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        fl, rdy, rsp, idr;
        logic [31:0] rdat;
        logic        e_rv, e_pw, e_iv;
        logic [31:0] e_ipc, e_iin;
    } vec_t;

    vec_t tbl[32];

    function automatic logic [31:0] dat(input logic [31:0] a);
        return a ^ 32'hA5A50000;
    endfunction

    function automatic vec_t mk(input logic [31:0] pc, input logic fl, input logic rdy, input logic rsp,
                                input logic [31:0] raddr, input logic idr, input logic rv, input logic pw,
                                input logic iv, input logic [31:0] ipc);
        vec_t v;
        v.pc = pc; v.fl = fl; v.rdy = rdy; v.rsp = rsp; v.idr = idr;
        v.rdat = rsp ? dat(raddr) : 32'h0;
        v.e_rv = rv; v.e_pw = pw; v.e_iv = iv;
        v.e_ipc = iv ? ipc : 32'h0;
        v.e_iin = iv ? dat(ipc) : 32'h0;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    task automatic drive(input logic [31:0] pc, input logic fl, input logic rdy, input logic rsp,
                         input logic [31:0] rdat, input logic idr);
        pc_current = pc; pc_flush = fl; imem_req_ready = rdy;
        imem_rsp_valid = rsp; imem_rsp_data = rdat; id_ready = idr;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pc_reg, exp_pc, pend_addr;
        logic pend, prev_rsp, hs;
        int got;
        //             pc        fl   rdy  rsp  raddr     idr  rv   pw   iv   ipc
        tbl[0]  = mk(32'h000, 1'b0, 1'b1, 1'b0, 32'h000, 1'b0, 1'b1, 1'b1, 1'b0, 32'h000);
        tbl[1]  = mk(32'h004, 1'b0, 1'b1, 1'b1, 32'h000, 1'b0, 1'b1, 1'b1, 1'b0, 32'h000);
        tbl[2]  = mk(32'h008, 1'b0, 1'b1, 1'b1, 32'h004, 1'b0, 1'b0, 1'b0, 1'b1, 32'h000);
        tbl[3]  = mk(32'h008, 1'b0, 1'b1, 1'b0, 32'h000, 1'b0, 1'b0, 1'b0, 1'b1, 32'h000);
        tbl[4]  = mk(32'h008, 1'b0, 1'b1, 1'b0, 32'h000, 1'b1, 1'b0, 1'b0, 1'b1, 32'h000);
        tbl[5]  = mk(32'h008, 1'b0, 1'b1, 1'b0, 32'h000, 1'b0, 1'b1, 1'b1, 1'b1, 32'h004);
        tbl[6]  = mk(32'h00C, 1'b0, 1'b1, 1'b1, 32'h008, 1'b0, 1'b0, 1'b0, 1'b1, 32'h004);
        tbl[7]  = mk(32'h00C, 1'b0, 1'b0, 1'b0, 32'h000, 1'b1, 1'b0, 1'b0, 1'b1, 32'h004);
        tbl[8]  = mk(32'h00C, 1'b0, 1'b0, 1'b0, 32'h000, 1'b1, 1'b1, 1'b0, 1'b1, 32'h008);
        tbl[9]  = mk(32'h00C, 1'b0, 1'b1, 1'b0, 32'h000, 1'b1, 1'b1, 1'b1, 1'b0, 32'h000);
        tbl[10] = mk(32'h010, 1'b0, 1'b1, 1'b0, 32'h000, 1'b1, 1'b1, 1'b1, 1'b0, 32'h000);
        tbl[11] = mk(32'h014, 1'b1, 1'b1, 1'b0, 32'h000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h000);
        tbl[12] = mk(32'h100, 1'b0, 1'b1, 1'b1, 32'h00C, 1'b1, 1'b0, 1'b0, 1'b0, 32'h000);
        tbl[13] = mk(32'h100, 1'b0, 1'b1, 1'b1, 32'h010, 1'b1, 1'b1, 1'b1, 1'b0, 32'h000);
        tbl[14] = mk(32'h104, 1'b0, 1'b1, 1'b1, 32'h100, 1'b1, 1'b1, 1'b1, 1'b0, 32'h000);
        tbl[15] = mk(32'h108, 1'b0, 1'b1, 1'b1, 32'h104, 1'b0, 1'b0, 1'b0, 1'b1, 32'h100);
        tbl[16] = mk(32'h108, 1'b0, 1'b1, 1'b0, 32'h000, 1'b1, 1'b0, 1'b0, 1'b1, 32'h100);
        tbl[17] = mk(32'h108, 1'b0, 1'b1, 1'b0, 32'h000, 1'b0, 1'b1, 1'b1, 1'b1, 32'h104);
        tbl[18] = mk(32'h10C, 1'b1, 1'b1, 1'b1, 32'h108, 1'b1, 1'b0, 1'b0, 1'b1, 32'h104);
        tbl[19] = mk(32'h200, 1'b0, 1'b1, 1'b0, 32'h000, 1'b1, 1'b1, 1'b1, 1'b0, 32'h000);
        tbl[20] = mk(32'h204, 1'b0, 1'b1, 1'b1, 32'h200, 1'b1, 1'b1, 1'b1, 1'b0, 32'h000);
        tbl[21] = mk(32'h208, 1'b0, 1'b0, 1'b1, 32'h204, 1'b1, 1'b0, 1'b0, 1'b1, 32'h200);
        tbl[22] = mk(32'h208, 1'b0, 1'b0, 1'b0, 32'h000, 1'b1, 1'b1, 1'b0, 1'b1, 32'h204);
        tbl[23] = mk(32'h208, 1'b0, 1'b0, 1'b0, 32'h000, 1'b1, 1'b1, 1'b0, 1'b0, 32'h000);
        tbl[24] = mk(32'h208, 1'b0, 1'b1, 1'b0, 32'h000, 1'b1, 1'b1, 1'b1, 1'b0, 32'h000);
        tbl[25] = mk(32'h20C, 1'b0, 1'b1, 1'b0, 32'h000, 1'b1, 1'b1, 1'b1, 1'b0, 32'h000);
        tbl[26] = mk(32'h210, 1'b1, 1'b1, 1'b1, 32'h208, 1'b1, 1'b0, 1'b0, 1'b0, 32'h000);
        tbl[27] = mk(32'h300, 1'b1, 1'b1, 1'b0, 32'h000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h000);
        tbl[28] = mk(32'h300, 1'b0, 1'b1, 1'b1, 32'h20C, 1'b1, 1'b1, 1'b1, 1'b0, 32'h000);
        tbl[29] = mk(32'h304, 1'b0, 1'b0, 1'b1, 32'h300, 1'b1, 1'b1, 1'b0, 1'b0, 32'h000);
        tbl[30] = mk(32'h304, 1'b0, 1'b0, 1'b0, 32'h000, 1'b1, 1'b1, 1'b0, 1'b1, 32'h300);
        tbl[31] = mk(32'h304, 1'b0, 1'b0, 1'b0, 32'h000, 1'b1, 1'b1, 1'b0, 1'b0, 32'h000);

        drive(32'h10, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst req_valid", 32'(imem_req_valid), 32'h0);
        check("rst pc_write", 32'(pc_write), 32'h0);
        check("rst id_valid", 32'(id_valid), 32'h0);
        check("rst id_pc", id_pc, 32'h0);
        check("rst id_instr", id_instr, 32'h0);
        check("rst req_addr", imem_req_addr, 32'h0);
        check("rst pc_next", pc_next, 32'h14);
        pc_current = 32'h0;
        #1;
        check("rst pc_next0", pc_next, 32'h4);
        @(negedge clk);
        rst_n = 1'b1;
        imem_req_ready = 1'b0;
        pc_current = 32'hFFFFFFFC;
        #1;
        check("wrap pc_next", pc_next, 32'h0);
        pc_current = 32'h13;
        #1;
        check("unaligned pc_next", pc_next, 32'h14);
        pc_current = 32'h0;
`ifdef FETCH_BYPASS_EN
        @(negedge clk);
        drive(32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        #1;
        check("byp req hs", 32'(pc_write), 32'h1);
        @(negedge clk);
        drive(32'h4, 1'b0, 1'b0, 1'b1, dat(32'h0), 1'b1);
        #1;
        check("byp id_valid", 32'(id_valid), 32'h1);
        check("byp id_pc", id_pc, 32'h0);
        check("byp id_instr", id_instr, dat(32'h0));
        @(negedge clk);
        drive(32'h4, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        #1;
        check("byp not queued", 32'(id_valid), 32'h0);
`else
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            drive(tbl[i].pc, tbl[i].fl, tbl[i].rdy, tbl[i].rsp, tbl[i].rdat, tbl[i].idr);
            #1;
            check($sformatf("t%0d req_valid", i), 32'(imem_req_valid), 32'(tbl[i].e_rv));
            check($sformatf("t%0d pc_write", i), 32'(pc_write), 32'(tbl[i].e_pw));
            check($sformatf("t%0d id_valid", i), 32'(id_valid), 32'(tbl[i].e_iv));
            check($sformatf("t%0d id_pc", i), id_pc, tbl[i].e_ipc);
            check($sformatf("t%0d id_instr", i), id_instr, tbl[i].e_iin);
            check($sformatf("t%0d req_addr", i), imem_req_addr, tbl[i].pc);
            check($sformatf("t%0d pc_next", i), pc_next, tbl[i].pc + 32'h4);
        end
        pc_reg = 32'hFFFFFFF0;
        exp_pc = 32'hFFFFFFF0;
        pend = 1'b0;
        pend_addr = '0;
        prev_rsp = 1'b0;
        got = 0;
        for (int c = 0; c < 60 && got < 12; c++) begin
            @(negedge clk);
            drive(pc_reg, 1'b0, 1'b1, pend, pend ? dat(pend_addr) : 32'h0, 1'b1);
            #1;
            if (prev_rsp) check("stream latency", 32'(id_valid), 32'h1);
            if (id_valid) begin
                check("stream id_pc", id_pc, exp_pc);
                check("stream id_instr", id_instr, dat(exp_pc));
                exp_pc += 32'h4;
                got++;
            end
            hs = imem_req_valid && imem_req_ready;
            prev_rsp = pend;
            pend = hs;
            pend_addr = pc_reg;
            if (hs) pc_reg += 32'h4;
        end
        check("stream entries", 32'(got), 32'd12);
`endif
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
